shift_add_mult8: RTL and testbench
==================================

# shift_add_mult8

Sequential signed 8×8 multiplier datapath and controller that drives the shared 9-bit add/subtract stage and consumes its sum. It holds the X:A:B product register and the latched multiplicand M. It sequences eight add/subtract-then-arithmetic-shift iterations and presents the 17-bit result X:A:B to the display and top level. It sits between the switch/button inputs and the hex displays in the lab-4 multiplier top.

## Interface
- Parameters: none; width is fixed at 8 because the adder stage is fixed at 9 bits.
- Clk  in  1  system clock; all state updates on the rising edge.
- Reset  in  1  asynchronous, active-low reset.
- start  in  1  level request to run one multiply; sampled only in IDLE.
- load_b  in  1  in IDLE: clear X and A, load B from din.
- din  in  8  switch value; the multiplier source on load_b and the multiplicand source on start.
- Aval  out  8  A register; the product high byte.
- Bval  out  8  B register; the product low byte.
- Xval  out  1  X sign-extension bit.
- busy  out  1  high in ADD and SHIFT.
- done  out  1  high in DONE.

## Operation
- States: IDLE, ADD, SHIFT, DONE. A 3-bit iteration counter cnt holds 0..7.
- Reset (Reset=0, asynchronous): X=0, A=0x00, B=0x00, M=0x00, cnt=0, state=IDLE, busy=0, done=0.
- IDLE, load_b=1:
  - B←din, A←0, X←0.
  - load_b has priority over start in the same cycle; start is ignored that cycle.
- IDLE, start=1 and load_b=0:
  - M←din, A←0, X←0, cnt←0, go to ADD.
  - B is retained.
- ADD:
  - If B[0]=1: adder operands are {A[7],A} and {M[7],M}.
    - cnt<7: add.
    - cnt=7: sub (two's complement of M, cin=1).
    - Result: X←S[8], A←S[7:0].
  - If B[0]=0: the adder is idle (add=sub=0) and X, A are unchanged.
  - Always go to SHIFT.
- SHIFT: arithmetic right shift of X:A:B.
  - X unchanged, A←{X,A[7:1]}, B←{A[0],B[7:1]}.
  - cnt=7: go to DONE. Otherwise cnt←cnt+1 and go to ADD.
- DONE: registers hold. Stay while start=1; go to IDLE when start=0. load_b is ignored.
- Invariant: X always equals the sign of the product. The adder carry-out is unused.
- start and load_b are ignored outside the states named above.

## Timing
- start sampled high in IDLE at edge t: ADD at t+1, SHIFT at t+2, and so on; last SHIFT at t+16, DONE from t+17.
- Latency is 17 cycles from start sample to done=1. The result is stable from the same edge as done.
- busy=1 for exactly 16 cycles per multiply.
- Back-to-back runs require start to drop for at least one cycle after DONE; the earliest next start is sampled at IDLE.
- Reset mid-operation clears everything asynchronously. No partial result is retained.
- load_b takes effect the edge after it is sampled in IDLE.

## Structure
- Package mult_pkg:
  - state enum mult_state_t {IDLE, ADD, SHIFT, DONE}
  - localparam N_ITER=8
  - localparam DW=8
- One sub-module: the existing 9-bit add/subtract stage PMAdder, driven combinationally with A, B, add, sub. Its S feeds the X:A load.
- The FSM and registers live in shift_add_mult8. No other hierarchy.

## Test plan
- Reset, then load_b with din=0xC5 (−59), then start with din=0x07 → done at t+17 with Xval=1, Aval=0xFE, Bval=0x63 (−413).
- load_b din=0x80, start din=0x80 (−128×−128) → Xval=0, Aval=0x40, Bval=0x00; checks the final-iteration subtract.
- load_b din=0xFF, start din=0xFF (−1×−1) → Xval=0, Aval=0x00, Bval=0x01. Also load_b din=0x7F, start din=0x7F → 0x3F01, Xval=0.
- Continuation: after the first scenario, keep start high for 5 cycles (DONE held, busy=0), drop it, then start with din=0x02 → result uses B=0x63 and gives Aval=0x00, Bval=0xC6, Xval=0.
- Mid-run reset: drive Reset=0 at cycle t+5 of a multiply → all outputs 0 immediately. After release the block is in IDLE, and start with load_b=1 in the same cycle loads B only and does not start.

Source files
------------

// File: rtl/shift_add_mult8_pkg.sv
// Shared types and sizing for the sequential signed 8x8 shift/add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } mult_state_t;

  localparam int N_ITER = 8;
  localparam int DW     = 8;

  localparam logic [2:0] LAST_ITER = 3'(N_ITER - 1);

endpackage

// File: rtl/shift_add_mult8_if.sv
// Switch/button inputs and product/status outputs of the multiplier.
//
// Handshake: start is a level request sampled only in IDLE; done stays high in
// DONE until start drops, so a new run needs start low for at least one cycle.
interface shift_add_mult8_if;

  logic                   start;
  logic                   load_b;
  logic [7:0]             din;
  logic [7:0]             Aval;
  logic [7:0]             Bval;
  logic                   Xval;
  logic                   busy;
  logic                   done;
  mult_pkg::mult_state_t  state_dbg;

  modport master (
    output start, load_b, din,
    input  Aval, Bval, Xval, busy, done, state_dbg
  );

  modport slave (
    input  start, load_b, din,
    output Aval, Bval, Xval, busy, done, state_dbg
  );

endinterface

// File: rtl/shift_add_mult8_pmadder.sv
// Shared 9-bit add/subtract stage; passes A through when neither add nor sub.
module PMAdder (
  input  logic [8:0] A,
  input  logic [8:0] B,
  input  logic       add,
  input  logic       sub,
  output logic [8:0] S
);

  always_comb begin
    S = A;
    if (sub) begin
      S = A + ~B + 9'd1;
    end else if (add) begin
      S = A + B;
    end
  end

endmodule

// File: rtl/shift_add_mult8.sv
// Signed 8x8 multiplier: eight add/sub-then-arithmetic-shift steps on X:A:B,
// with the final step subtracting M to account for the multiplier sign bit.
module shift_add_mult8
  import mult_pkg::*;
(
  input  logic              Clk,
  input  logic              Reset,
  shift_add_mult8_if.slave  bus
);

  mult_state_t state, state_nxt;
  logic        x, x_nxt;
  logic [7:0]  a, a_nxt;
  logic [7:0]  b, b_nxt;
  logic [7:0]  m, m_nxt;
  logic [2:0]  cnt, cnt_nxt;

  logic        adder_add;
  logic        adder_sub;
  logic [8:0]  adder_s;

  assign adder_add = (state == ADD) && b[0] && (cnt != LAST_ITER);
  assign adder_sub = (state == ADD) && b[0] && (cnt == LAST_ITER);

  PMAdder u_adder (
    .A   ({a[7], a}),
    .B   ({m[7], m}),
    .add (adder_add),
    .sub (adder_sub),
    .S   (adder_s)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state <= IDLE;
      x     <= 1'b0;
      a     <= '0;
      b     <= '0;
      m     <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      x     <= x_nxt;
      a     <= a_nxt;
      b     <= b_nxt;
      m     <= m_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    x_nxt     = x;
    a_nxt     = a;
    b_nxt     = b;
    m_nxt     = m;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        // load_b wins over start so the multiplier can be set up first.
        if (bus.load_b) begin
          b_nxt = bus.din;
          a_nxt = '0;
          x_nxt = 1'b0;
        end else if (bus.start) begin
          m_nxt     = bus.din;
          a_nxt     = '0;
          x_nxt     = 1'b0;
          cnt_nxt   = '0;
          state_nxt = ADD;
        end
      end
      ADD: begin
        if (b[0]) begin
          x_nxt = adder_s[8];
          a_nxt = adder_s[7:0];
        end
        state_nxt = SHIFT;
      end
      SHIFT: begin
        a_nxt = {x, a[7:1]};
        b_nxt = {a[0], b[7:1]};
        if (cnt == LAST_ITER) begin
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + 3'd1;
          state_nxt = ADD;
        end
      end
      DONE: begin
        if (!bus.start) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.Aval      = a;
  assign bus.Bval      = b;
  assign bus.Xval      = x;
  assign bus.busy      = (state == ADD) || (state == SHIFT);
  assign bus.done      = (state == DONE);
  assign bus.state_dbg = state;

endmodule

// File: tb/tb_shift_add_mult8.sv
// Directed bench for shift_add_mult8: vector table plus hand-written sequences
// for DONE hold, back-to-back continuation and mid-run reset.
module tb_shift_add_mult8;
  import mult_pkg::*;

  logic clk;
  logic rst_n;

  shift_add_mult8_if bus ();

  shift_add_mult8 dut (
    .Clk   (clk),
    .Reset (rst_n),
    .bus   (bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] b_in;
    logic [7:0] m_in;
    logic       exp_x;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver tasks
  task automatic do_load(input logic [7:0] v);
    bus.din    = v;
    bus.load_b = 1'b1;
    bus.start  = 1'b0;
    tick();
    bus.load_b = 1'b0;
  endtask

  task automatic do_start(input logic [7:0] v, output int lat, output int busy_n);
    bus.din    = v;
    bus.start  = 1'b1;
    bus.load_b = 1'b0;
    tick();
    bus.din = 8'h00;
    lat     = 1;
    busy_n  = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) busy_n++;
      tick();
      lat++;
    end
  endtask

  task automatic check_result(input string name, input logic x, input logic [7:0] a,
                              input logic [7:0] b);
    check({name, ".X"}, 32'(bus.Xval), 32'(x));
    check({name, ".A"}, 32'(bus.Aval), 32'(a));
    check({name, ".B"}, 32'(bus.Bval), 32'(b));
  endtask

  task automatic end_run(input string name);
    bus.start = 1'b0;
    tick();
    check({name, ".idle"}, 32'(bus.state_dbg), 32'(IDLE));
  endtask

  initial begin
    int lat;
    int busy_n;

    vecs[0] = '{8'hC5, 8'h07, 1'b1, 8'hFE, 8'h63};  // -59 * 7     = -413
    vecs[1] = '{8'h80, 8'h80, 1'b0, 8'h40, 8'h00};  // -128 * -128 = 16384
    vecs[2] = '{8'hFF, 8'hFF, 1'b0, 8'h00, 8'h01};  // -1 * -1     = 1
    vecs[3] = '{8'h7F, 8'h7F, 1'b0, 8'h3F, 8'h01};  // 127 * 127   = 16129
    vecs[4] = '{8'h80, 8'h7F, 1'b1, 8'hC0, 8'h80};  // -128 * 127  = -16256
    vecs[5] = '{8'h03, 8'hFB, 1'b1, 8'hFF, 8'hF1};  // 3 * -5      = -15
    vecs[6] = '{8'h5A, 8'h00, 1'b0, 8'h00, 8'h00};  // 90 * 0      = 0

    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.load_b = 1'b0;
    bus.din    = 8'h00;
    tick();
    tick();
    check_result("reset", 1'b0, 8'h00, 8'h00);
    check("reset.busy", 32'(bus.busy), 32'd0);
    check("reset.done", 32'(bus.done), 32'd0);
    check("reset.state", 32'(bus.state_dbg), 32'(IDLE));
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) begin
      do_load(vecs[i].b_in);
      check($sformatf("v%0d.load_b", i), 32'(bus.Bval), 32'(vecs[i].b_in));
      do_start(vecs[i].m_in, lat, busy_n);
      check($sformatf("v%0d.latency", i), 32'(lat), 32'd17);
      check($sformatf("v%0d.busy_cycles", i), 32'(busy_n), 32'd16);
      check_result($sformatf("v%0d", i), vecs[i].exp_x, vecs[i].exp_a, vecs[i].exp_b);
      end_run($sformatf("v%0d", i));
    end

    // DONE held while start stays high; load_b must not disturb the result
    do_load(8'hC5);
    do_start(8'h07, lat, busy_n);
    check("cont.latency", 32'(lat), 32'd17);
    bus.load_b = 1'b1;
    bus.din    = 8'hAA;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold%0d.done", k), 32'(bus.done), 32'd1);
      check($sformatf("hold%0d.busy", k), 32'(bus.busy), 32'd0);
      check($sformatf("hold%0d.B", k), 32'(bus.Bval), 32'h63);
    end
    bus.load_b = 1'b0;
    end_run("cont");
    do_start(8'h02, lat, busy_n);
    check("cont2.latency", 32'(lat), 32'd17);
    check_result("cont2", 1'b0, 8'h00, 8'hC6);
    end_run("cont2");

    // reset in the middle of a run clears everything without a clock edge
    do_load(8'h11);
    bus.din   = 8'h22;
    bus.start = 1'b1;
    tick();
    for (int k = 0; k < 4; k++) tick();
    check("mid.busy_before", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_result("mid.rst", 1'b0, 8'h00, 8'h00);
    check("mid.rst.busy", 32'(bus.busy), 32'd0);
    check("mid.rst.state", 32'(bus.state_dbg), 32'(IDLE));
    #1;
    rst_n      = 1'b1;
    bus.load_b = 1'b1;
    bus.din    = 8'h5A;
    tick();
    bus.load_b = 1'b0;
    bus.start  = 1'b0;
    check("prio.B", 32'(bus.Bval), 32'h5A);
    check("prio.busy", 32'(bus.busy), 32'd0);
    check("prio.state", 32'(bus.state_dbg), 32'(IDLE));
    tick();
    check("prio.still_idle", 32'(bus.state_dbg), 32'(IDLE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
